// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I opcodes, optype one-hot bit indices and encoder error-cause codes
package rv_isa_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam int OT_R      = 0;
  localparam int OT_I      = 1;
  localparam int OT_LOAD   = 2;
  localparam int OT_STORE  = 3;
  localparam int OT_BRANCH = 4;
  localparam int OT_JAL    = 5;
  localparam int OT_JALR   = 6;
  localparam int OT_LUI    = 7;
  localparam int OT_AUIPC  = 8;
  localparam int OT_SYSTEM = 9;
  localparam int OT_RSVD   = 10;
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPTYPE = 2'd1;
  localparam logic [1:0] CAUSE_RANGE  = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN  = 2'd3;
endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational RV32I field packing with immediate legality checks
module instr_field_pack
  import rv_isa_pkg::*;
(
  input  logic [10:0] optype,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal,
  output logic [1:0]  cause
);
  logic [9:0] ot;
  logic signed [31:0] si;
  logic onehot, is_i12, is_u, shift, fits12, fits_b, fits_j, range_ok, align_ok;
  assign ot = optype[9:0];
  assign si = imm;
  assign onehot = (ot != '0) && ((ot & (ot - 10'd1)) == '0) && !optype[OT_RSVD];
  assign is_i12 = ot[OT_I] | ot[OT_LOAD] | ot[OT_JALR] | ot[OT_SYSTEM];
  assign is_u = ot[OT_LUI] | ot[OT_AUIPC];
  assign shift = ot[OT_I] && (funct3 == 3'b001 || funct3 == 3'b101);
  assign fits12 = si >= -32'sd2048 && si <= 32'sd2047;
  assign fits_b = si >= -32'sd4096 && si <= 32'sd4094;
  assign fits_j = si >= -32'sd1048576 && si <= 32'sd1048574;
  assign range_ok = ot[OT_R] ? 1'b1 :
                    shift ? imm[31:5] == '0 :
                    (is_i12 | ot[OT_STORE]) ? fits12 :
                    ot[OT_BRANCH] ? fits_b :
                    ot[OT_JAL] ? fits_j :
                    is_u ? imm[11:0] == '0 : 1'b1;
  assign align_ok = !((ot[OT_BRANCH] | ot[OT_JAL]) && imm[0]);
  assign cause = !onehot ? CAUSE_OPTYPE : !range_ok ? CAUSE_RANGE :
                 !align_ok ? CAUSE_ALIGN : CAUSE_NONE;
  assign legal = cause == CAUSE_NONE;
  always_comb begin
    word = '0;
    if (ot[OT_R])      word = {funct7, rs2, rs1, funct3, rd, OP_R};
    if (ot[OT_I])      word = {shift ? funct7 : imm[11:5], imm[4:0], rs1, funct3, rd, OP_I};
    if (ot[OT_LOAD])   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
    if (ot[OT_JALR])   word = {imm[11:0], rs1, funct3, rd, OP_JALR};
    if (ot[OT_SYSTEM]) word = {imm[11:0], rs1, funct3, rd, OP_SYSTEM};
    if (ot[OT_STORE])  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
    if (ot[OT_BRANCH]) word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
    if (ot[OT_LUI])    word = {imm[31:12], rd, OP_LUI};
    if (ot[OT_AUIPC])  word = {imm[31:12], rd, OP_AUIPC};
    if (ot[OT_JAL])    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level requests, encodes RV32I words and streams them to IMEM
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       optype,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              err_clr,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic [ADDR_W:0]   enc_count,
  output logic              err,
  output logic [1:0]        err_cause
);
  typedef enum logic [1:0] {IDLE, PEND, FULL} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0] word;
  logic legal, accept, legal_acc, bad_acc, full_nxt;
  logic [1:0] cause;
  instr_field_pack u_pack (
    .optype(optype), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .word(word), .legal(legal), .cause(cause)
  );
  assign imem_we = state == PEND;
  assign in_ready = !full && (!imem_we || imem_ready);
  assign accept = in_valid && in_ready;
  assign legal_acc = accept && legal;
  assign bad_acc = accept && !legal;
  assign full_nxt = base_load ? 1'b0 : (legal_acc && ptr == '1) ? 1'b1 : full;
  always_comb begin
    state_nxt = state;
    if (legal_acc) state_nxt = PEND;
    else if (state == PEND && imem_ready) state_nxt = full_nxt ? FULL : IDLE;
    else if (state == FULL && base_load) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      full       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      enc_count  <= '0;
      err        <= 1'b0;
      err_cause  <= CAUSE_NONE;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      ptr   <= base_load ? base_addr : legal_acc ? ptr + 1'b1 : ptr;
      if (legal_acc) begin
        imem_addr  <= ptr;
        imem_wdata <= word;
        enc_count  <= enc_count + 1'b1;
      end
      err <= bad_acc | (err & ~err_clr);
      // the first cause since the last clear sticks; a same-cycle clear lets a new error overwrite it
      err_cause <= bad_acc ? ((err && !err_clr) ? err_cause : cause) :
                   err_clr ? CAUSE_NONE : err_cause;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder (ADDR_W=2 to reach full quickly)
module tb_instr_encoder;
  localparam int AW = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready;
  logic [10:0] optype = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [2:0] funct3 = 0;
  logic [6:0] funct7 = 0;
  logic [31:0] imm = 0;
  logic base_load = 0, err_clr = 0, imem_ready = 1;
  logic [AW-1:0] base_addr = 0;
  logic imem_we, full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] enc_count;
  logic [1:0] err_cause;
  int n = 0, bad = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .optype(optype), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .base_load(base_load), .base_addr(base_addr),
    .err_clr(err_clr), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .full(full),
    .enc_count(enc_count), .err(err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] o, input logic [4:0] d, s1, s2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    optype = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1;
  endtask

  task automatic do_reset;
    in_valid = 0; base_load = 0; err_clr = 0; imem_ready = 1;
    rst_n = 0;
    tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_reset;
    in_valid = 0;
    rst_n = 0;
    #3;
    n++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_we got %b want 0", imem_we); end
    n++; if (imem_addr !== '0) begin bad++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    n++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
    n++; if ({full, err, err_cause} !== 4'b0) begin bad++; $display("FAIL rst_flags got %b want 0000", {full, err, err_cause}); end
    n++; if (enc_count !== '0) begin bad++; $display("FAIL rst_count got %0d want 0", enc_count); end
    n++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", in_ready); end
    tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_rtype;
    do_reset;
    drive(11'h001, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
    tick;
    in_valid = 0;
    n++; if (imem_we !== 1'b1) begin bad++; $display("FAIL r_we got %b want 1", imem_we); end
    n++; if (imem_wdata !== 32'h402081B3) begin bad++; $display("FAIL r_word got %h want 402081b3", imem_wdata); end
    n++; if (imem_addr !== 2'd0) begin bad++; $display("FAIL r_addr got %0d want 0", imem_addr); end
    tick;
    n++; if (imem_we !== 1'b0) begin bad++; $display("FAIL r_we_drop got %b want 0", imem_we); end
    n++; if (enc_count !== 3'd1) begin bad++; $display("FAIL r_count got %0d want 1", enc_count); end
  endtask

  task automatic test_branch_store;
    do_reset;
    drive(11'h010, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, -32'sd4);
    tick;
    n++; if (imem_wdata !== 32'hFE208EE3) begin bad++; $display("FAIL br_word got %h want fe208ee3", imem_wdata); end
    drive(11'h008, 5'd0, 5'd2, 5'd5, 3'd2, 7'h0, 32'd8);
    tick;
    in_valid = 0;
    n++; if (imem_wdata !== 32'h00512423) begin bad++; $display("FAIL st_word got %h want 00512423", imem_wdata); end
    n++; if (imem_addr !== 2'd1) begin bad++; $display("FAIL st_addr got %0d want 1", imem_addr); end
    tick;
  endtask

  task automatic test_jal;
    do_reset;
    drive(11'h020, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
    tick;
    in_valid = 0;
    n++; if (imem_wdata !== 32'h001000EF) begin bad++; $display("FAIL jal_word got %h want 001000ef", imem_wdata); end
    tick;
    drive(11'h020, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3);
    tick;
    in_valid = 0;
    n++; if (imem_we !== 1'b0) begin bad++; $display("FAIL jal_bad_we got %b want 0", imem_we); end
    n++; if (err !== 1'b1) begin bad++; $display("FAIL jal_err got %b want 1", err); end
    n++; if (err_cause !== 2'd3) begin bad++; $display("FAIL jal_cause got %0d want 3", err_cause); end
    n++; if (enc_count !== 3'd1) begin bad++; $display("FAIL jal_count got %0d want 1", enc_count); end
    drive(11'h001, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
    tick;
    in_valid = 0;
    n++; if (imem_addr !== 2'd1) begin bad++; $display("FAIL jal_ptr got %0d want 1", imem_addr); end
    tick;
  endtask

  task automatic test_backpressure;
    do_reset;
    imem_ready = 0;
    drive(11'h001, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
    tick;
    rd = 5'd4;
    for (int i = 0; i < 3; i++) begin
      n++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
      n++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd0, 32'h402081B3})
        begin bad++; $display("FAIL bp_hold[%0d] got %b/%0d/%h want 1/0/402081b3", i, imem_we, imem_addr, imem_wdata); end
      tick;
    end
    imem_ready = 1;
    tick;
    rd = 5'd5;
    n++; if ({imem_addr, imem_wdata} !== {2'd1, 32'h40208233}) begin bad++; $display("FAIL bp_w1 got %0d/%h want 1/40208233", imem_addr, imem_wdata); end
    tick;
    in_valid = 0;
    n++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd2, 32'h402082B3}) begin bad++; $display("FAIL bp_w2 got %b/%0d/%h want 1/2/402082b3", imem_we, imem_addr, imem_wdata); end
    tick;
    n++; if (enc_count !== 3'd3) begin bad++; $display("FAIL bp_count got %0d want 3", enc_count); end
  endtask

  task automatic test_full;
    do_reset;
    drive(11'h001, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
    repeat (4) tick;
    in_valid = 0;
    n++; if ({full, in_ready} !== 2'b10) begin bad++; $display("FAIL full_set got full=%b ready=%b want 1/0", full, in_ready); end
    n++; if ({imem_addr, enc_count} !== {2'd3, 3'd4}) begin bad++; $display("FAIL full_last got addr=%0d cnt=%0d want 3/4", imem_addr, enc_count); end
    tick;
    n++; if ({imem_we, in_ready} !== 2'b00) begin bad++; $display("FAIL full_idle got we=%b ready=%b want 0/0", imem_we, in_ready); end
    base_load = 1; base_addr = 2'd1;
    tick;
    base_load = 0;
    n++; if ({full, in_ready} !== 2'b01) begin bad++; $display("FAIL full_clr got full=%b ready=%b want 0/1", full, in_ready); end
    drive(11'h001, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
    tick;
    in_valid = 0;
    n++; if ({imem_we, imem_addr} !== {1'b1, 2'd1}) begin bad++; $display("FAIL full_rebase got we=%b addr=%0d want 1/1", imem_we, imem_addr); end
    tick;
  endtask

  task automatic test_errors;
    do_reset;
    drive(11'h003, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
    tick;
    in_valid = 0;
    n++; if ({err, err_cause} !== 3'b101) begin bad++; $display("FAIL ot_err got %b/%0d want 1/1", err, err_cause); end
    drive(11'h020, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
    tick;
    in_valid = 0;
    n++; if (err_cause !== 2'd1) begin bad++; $display("FAIL sticky_cause got %0d want 1", err_cause); end
    err_clr = 1;
    drive(11'h002, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5000);
    tick;
    in_valid = 0; err_clr = 0;
    n++; if ({err, err_cause} !== 3'b110) begin bad++; $display("FAIL clr_new got %b/%0d want 1/2", err, err_cause); end
    err_clr = 1;
    tick;
    err_clr = 0;
    n++; if ({err, err_cause} !== 3'b000) begin bad++; $display("FAIL clr got %b/%0d want 0/0", err, err_cause); end
    drive(11'h002, 5'd1, 5'd2, 5'd0, 3'd1, 7'h0, 32'd32);
    tick;
    in_valid = 0;
    n++; if ({err, err_cause} !== 3'b110) begin bad++; $display("FAIL shamt got %b/%0d want 1/2", err, err_cause); end
    n++; if (enc_count !== 3'd0) begin bad++; $display("FAIL err_count got %0d want 0", enc_count); end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_branch_store;
    test_jal;
    test_backpressure;
    test_full;
    test_errors;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, bad);
    $finish;
  end
endmodule
